csc_dec_hls_deadlock_report_unit: RTL and testbench

Consumer side of the csc_dec HLS deadlock monitor. It takes the monitor's per-cycle block indication and the AXI-stream block signals that feed it. It qualifies a deadlock only when block persists for THRESH consecutive cycles. It then emits one timestamped report over a valid/ready handshake and keeps a sticky flag and an event counter for the debug/status path.

---
 rtl/csc_dec_hls_deadlock_report_unit.sv | 100 ++++++++++
 tb/tb_csc_dec_hls_deadlock_report_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_dec_hls_deadlock_report_unit.sv
// csc_dec HLS deadlock report unit: qualifies persistent block runs and
// emits one timestamped report per deadlock plus sticky status.
module csc_dec_hls_deadlock_report_unit #(
  parameter int NUM_SIGS = 4,
  parameter int THRESH   = 16,
  parameter int CNT_W    = 8,
  parameter int TS_W     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [NUM_SIGS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [NUM_SIGS-1:0] rpt_sigs,
  output logic [TS_W-1:0]     rpt_stamp,
  output logic                deadlock_flag,
  output logic [7:0]          deadlock_count
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    REPORT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);

  state_t              state;
  logic [TS_W-1:0]     ts;
  logic [CNT_W-1:0]    run_cnt;
  logic [NUM_SIGS-1:0] acc;
  logic                qualify;

  assign qualify = (state == ARMED) && block_in && (run_cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARMED;
      run_cnt   <= '0;
      acc       <= '0;
      rpt_valid <= 1'b0;
      rpt_sigs  <= '0;
      rpt_stamp <= '0;
    end else begin
      unique case (state)
        ARMED: begin
          if (qualify) begin
            rpt_sigs  <= acc | axis_block_sigs;
            rpt_stamp <= ts;
            rpt_valid <= 1'b1;
            run_cnt   <= '0;
            acc       <= '0;
            state     <= REPORT;
          end else if (block_in) begin
            run_cnt <= run_cnt + 1'b1;
            acc     <= acc | axis_block_sigs;
          end else begin
            run_cnt <= '0;
            acc     <= '0;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            state     <= HOLD;
          end
        end
        // one report per continuous block: re-arm only after a low sample
        HOLD: begin
          if (!block_in) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deadlock_flag  <= 1'b0;
      deadlock_count <= '0;
    end else if (qualify) begin
      deadlock_flag <= 1'b1;
      if (clear)
        deadlock_count <= 8'd1;
      else if (deadlock_count != 8'hFF)
        deadlock_count <= deadlock_count + 1'b1;
    end else if (clear) begin
      deadlock_flag  <= 1'b0;
      deadlock_count <= '0;
    end
  end

endmodule

// File: tb/tb_csc_dec_hls_deadlock_report_unit.sv
// Bench for csc_dec_hls_deadlock_report_unit: directed scenarios plus
// randomized traffic against a run-length reference model.
module tb_csc_dec_hls_deadlock_report_unit;

  localparam int NS  = 4;
  localparam int TH  = 16;
  localparam int TSW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset, block_in, clear, rpt_ready;
  logic [NS-1:0]  axis_block_sigs;
  logic           rpt_valid, deadlock_flag;
  logic [NS-1:0]  rpt_sigs;
  logic [TSW-1:0] rpt_stamp;
  logic [7:0]     deadlock_count;

  logic           reset_1, block_in_1, clear_1, rpt_ready_1;
  logic [NS-1:0]  axis_block_sigs_1;
  logic           rpt_valid_1, deadlock_flag_1;
  logic [NS-1:0]  rpt_sigs_1;
  logic [TSW-1:0] rpt_stamp_1;
  logic [7:0]     deadlock_count_1;

  csc_dec_hls_deadlock_report_unit #(
    .NUM_SIGS(NS), .THRESH(TH), .CNT_W(8), .TS_W(TSW)
  ) dut (
    .clock(clock), .reset(reset), .block_in(block_in),
    .axis_block_sigs(axis_block_sigs), .clear(clear),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_sigs(rpt_sigs), .rpt_stamp(rpt_stamp),
    .deadlock_flag(deadlock_flag), .deadlock_count(deadlock_count)
  );

  csc_dec_hls_deadlock_report_unit #(
    .NUM_SIGS(NS), .THRESH(1), .CNT_W(8), .TS_W(TSW)
  ) dut_1 (
    .clock(clock), .reset(reset_1), .block_in(block_in_1),
    .axis_block_sigs(axis_block_sigs_1), .clear(clear_1),
    .rpt_valid(rpt_valid_1), .rpt_ready(rpt_ready_1),
    .rpt_sigs(rpt_sigs_1), .rpt_stamp(rpt_stamp_1),
    .deadlock_flag(deadlock_flag_1), .deadlock_count(deadlock_count_1)
  );

  int total = 0;
  int bad   = 0;

  // reference model: run length, OR of the run, pending report, wait-for-low
  logic [TSW-1:0] m_ts, m_stamp;
  int             m_run, m_cnt;
  logic [NS-1:0]  m_or, m_sigs;
  bit             m_valid, m_flag, m_wait;

  task automatic model_reset();
    m_ts = '0; m_stamp = '0; m_run = 0; m_cnt = 0;
    m_or = '0; m_sigs = '0;
    m_valid = 0; m_flag = 0; m_wait = 0;
  endtask

  task automatic tick(input bit b, input logic [NS-1:0] s,
                      input bit rdy, input bit clr);
    bit q;
    block_in = b; axis_block_sigs = s; rpt_ready = rdy; clear = clr;
    @(posedge clock);
    q = 0;
    if (m_valid) begin
      if (rdy) begin m_valid = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (!b) m_wait = 0;
    end else if (b) begin
      m_run = m_run + 1;
      m_or  = m_or | s;
      if (m_run >= TH) begin
        q = 1; m_valid = 1; m_sigs = m_or; m_stamp = m_ts;
        m_run = 0; m_or = '0;
      end
    end else begin
      m_run = 0; m_or = '0;
    end
    if (q) begin
      m_flag = 1;
      m_cnt  = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_flag = 0; m_cnt = 0;
    end
    m_ts = m_ts + 1;
    #1;
  endtask

  task automatic do_reset();
    block_in = 0; axis_block_sigs = '0; rpt_ready = 0; clear = 0;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    block_in = 0; axis_block_sigs = '0; rpt_ready = 0; clear = 0;
    reset = 1;
    #1;
    total++;
    if (rpt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%0b exp=0", rpt_valid);
    end
    total++;
    if (rpt_sigs !== '0 || rpt_stamp !== '0) begin
      bad++; $display("FAIL reset_rpt got=%h/%0d exp=0/0", rpt_sigs, rpt_stamp);
    end
    total++;
    if (deadlock_flag !== 1'b0 || deadlock_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_status got=%0b/%0d exp=0/0",
               deadlock_flag, deadlock_count);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int early;
    do_reset();
    early = 0;
    for (int i = 0; i < 10; i++) tick(0, '0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      tick(1, 4'b0100, 1, 0);
      if (i < 15 && rpt_valid !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL basic_early got=%0d exp=0", early);
    end
    total++;
    if (rpt_valid !== 1'b1) begin
      bad++; $display("FAIL basic_valid got=%0b exp=1", rpt_valid);
    end
    total++;
    if (rpt_sigs !== 4'b0100) begin
      bad++; $display("FAIL basic_sigs got=%b exp=0100", rpt_sigs);
    end
    total++;
    if (rpt_stamp !== 32'd25 || rpt_stamp !== m_stamp) begin
      bad++; $display("FAIL basic_stamp got=%0d exp=25", rpt_stamp);
    end
    total++;
    if (deadlock_flag !== 1'b1 || deadlock_count !== 8'd1) begin
      bad++;
      $display("FAIL basic_status got=%0b/%0d exp=1/1",
               deadlock_flag, deadlock_count);
    end
    tick(0, '0, 1, 0);
    total++;
    if (rpt_valid !== 1'b0 || deadlock_flag !== 1'b1) begin
      bad++;
      $display("FAIL basic_accept got=%0b/%0b exp=0/1",
               rpt_valid, deadlock_flag);
    end
  endtask

  task automatic test_rerun();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1, 4'b0010, 0, 0);
      if (rpt_valid === 1'b1) pulses++;
    end
    tick(0, 4'b0010, 0, 0);
    if (rpt_valid === 1'b1) pulses++;
    for (int i = 0; i < 16; i++) begin
      tick(1, (i % 3 == 0) ? 4'b1000 : 4'b0001, 0, 0);
      if (rpt_valid === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL rerun_pulses got=%0d exp=1", pulses);
    end
    total++;
    if (rpt_sigs !== 4'b1001) begin
      bad++; $display("FAIL rerun_sigs got=%b exp=1001", rpt_sigs);
    end
    total++;
    if (rpt_stamp !== 32'd31) begin
      bad++; $display("FAIL rerun_stamp got=%0d exp=31", rpt_stamp);
    end
    tick(0, '0, 1, 0);
  endtask

  task automatic test_stall();
    int unstable, extra;
    do_reset();
    for (int i = 0; i < 16; i++) tick(1, 4'b0110, 0, 0);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom_range(0, 1)), 4'($urandom), 0, 0);
      if (rpt_valid !== 1'b1 || rpt_sigs !== 4'b0110 || rpt_stamp !== 32'd15)
        unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL stall_hold got=%0d exp=0 unstable cycles", unstable);
    end
    tick(1, 4'b0001, 1, 0);
    total++;
    if (rpt_valid !== 1'b0) begin
      bad++; $display("FAIL stall_accept got=%0b exp=0", rpt_valid);
    end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1, 4'($urandom), 1, 0);
      if (rpt_valid === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL stall_noreport got=%0d exp=0", extra);
    end
    tick(0, '0, 1, 0);
    for (int i = 0; i < 16; i++) tick(1, 4'b1000, 0, 0);
    total++;
    if (rpt_valid !== 1'b1 || deadlock_count !== 8'd2) begin
      bad++;
      $display("FAIL stall_second got=%0b/%0d exp=1/2",
               rpt_valid, deadlock_count);
    end
    tick(0, '0, 1, 0);
  endtask

  task automatic test_clear();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) tick(1, 4'($urandom), 1, 0);
      tick(0, '0, 1, 0);
      tick(0, '0, 1, 0);
    end
    total++;
    if (deadlock_count !== 8'd3) begin
      bad++; $display("FAIL clear_pre got=%0d exp=3", deadlock_count);
    end
    for (int i = 0; i < 15; i++) tick(1, 4'b0001, 1, 0);
    tick(1, 4'b0001, 1, 1);
    total++;
    if (deadlock_flag !== 1'b1 || deadlock_count !== 8'd1 || rpt_valid !== 1'b1) begin
      bad++;
      $display("FAIL clear_collide got=%0b/%0d/%0b exp=1/1/1",
               deadlock_flag, deadlock_count, rpt_valid);
    end
    tick(0, '0, 1, 0);
    tick(0, '0, 1, 1);
    total++;
    if (deadlock_flag !== 1'b0 || deadlock_count !== 8'd0) begin
      bad++;
      $display("FAIL clear_idle got=%0b/%0d exp=0/0",
               deadlock_flag, deadlock_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 16; i++) tick(1, 4'b0011, 0, 0);
    total++;
    if (rpt_valid !== 1'b1) begin
      bad++; $display("FAIL areset_pre got=%0b exp=1", rpt_valid);
    end
    #2 reset = 1;
    #1;
    total++;
    if (rpt_valid !== 1'b0 || deadlock_flag !== 1'b0 || deadlock_count !== 8'd0) begin
      bad++;
      $display("FAIL areset_drop got=%0b/%0b/%0d exp=0/0/0",
               rpt_valid, deadlock_flag, deadlock_count);
    end
    #2 reset = 0;
    model_reset();
    for (int i = 0; i < 16; i++) tick(1, 4'b0100, 0, 0);
    total++;
    if (rpt_valid !== 1'b1 || rpt_stamp !== 32'd15) begin
      bad++;
      $display("FAIL areset_restart got=%0b/%0d exp=1/15",
               rpt_valid, rpt_stamp);
    end
    tick(0, '0, 1, 0);
  endtask

  task automatic test_random();
    bit b, rdy, clr;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      b   = ($urandom_range(0, 19) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      tick(b, 4'($urandom), rdy, clr);
      total++;
      if (rpt_valid !== m_valid) begin
        bad++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", i, rpt_valid, m_valid);
      end
      total++;
      if (rpt_sigs !== m_sigs || rpt_stamp !== m_stamp) begin
        bad++;
        $display("FAIL rand_rpt cyc=%0d got=%b/%0d exp=%b/%0d",
                 i, rpt_sigs, rpt_stamp, m_sigs, m_stamp);
      end
      total++;
      if (deadlock_flag !== m_flag || deadlock_count !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL rand_status cyc=%0d got=%0b/%0d exp=%0b/%0d",
                 i, deadlock_flag, deadlock_count, m_flag, m_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    logic [NS-1:0] s;
    int seen, wrong;
    seen = 0; wrong = 0;
    rpt_ready_1 = 1; clear_1 = 0; block_in_1 = 0; axis_block_sigs_1 = '0;
    @(negedge clock);
    reset_1 = 0;
    for (int i = 0; i < 260; i++) begin
      s = 4'($urandom_range(1, 15));
      block_in_1 = 1; axis_block_sigs_1 = s;
      @(posedge clock); #1;
      if (rpt_valid_1 === 1'b1) seen++;
      if (rpt_sigs_1 !== s || rpt_stamp_1 !== 32'(3 * i) ||
          deadlock_count_1 !== 8'((i + 1 < 255) ? i + 1 : 255))
        wrong++;
      block_in_1 = 0; axis_block_sigs_1 = '0;
      @(posedge clock); #1;
      @(posedge clock); #1;
    end
    total++;
    if (seen != 260) begin
      bad++; $display("FAIL sat_reports got=%0d exp=260", seen);
    end
    total++;
    if (wrong != 0) begin
      bad++; $display("FAIL sat_fields got=%0d exp=0 wrong reports", wrong);
    end
    total++;
    if (deadlock_count_1 !== 8'd255 || deadlock_flag_1 !== 1'b1) begin
      bad++;
      $display("FAIL sat_count got=%0d/%0b exp=255/1",
               deadlock_count_1, deadlock_flag_1);
    end
  endtask

  initial begin
    reset_1 = 1; block_in_1 = 0; clear_1 = 0; rpt_ready_1 = 0;
    axis_block_sigs_1 = '0;
    reset = 1; block_in = 0; clear = 0; rpt_ready = 0; axis_block_sigs = '0;
    model_reset();
    #12;
    test_reset();
    test_basic();
    test_rerun();
    test_stall();
    test_clear();
    test_async_reset();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
